// File: rtl/karat_core_arbiter.sv
// Round-robin arbiter that shares one Karatsuba multiplier core between NREQ requesters.
// It latches the winner's operand addresses, sequences the core's reset/run handshake and enforces a watchdog.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no owner; arbitrate among req, latch winner and its addresses
// GRANT   | owner granted, core held in reset while addresses settle
// RUN     | core released; wait for karatDone or watchdog expiry
// DONE    | one-cycle done pulse to owner, advance round-robin pointer
// ABORT   | one-cycle abort pulse to owner, advance round-robin pointer
module karat_core_arbiter #(
    parameter int NREQ    = 2,
    parameter int ADDR_W  = 2,
    parameter int MAX_CYC = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*ADDR_W-1:0] req_addra,
    input  logic [NREQ*ADDR_W-1:0] req_addrb,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        done,
    output logic [NREQ-1:0]        abort,
    output logic [ADDR_W-1:0]      addra,
    output logic [ADDR_W-1:0]      addrb,
    output logic                   karatRst,
    input  logic                   karatDone,
    output logic                   busy
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int WD_W  = $clog2(MAX_CYC + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(MAX_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_RUN,
        ST_DONE,
        ST_ABORT
    } state_t;

    state_t            state, state_nxt;
    logic [NREQ-1:0]   gnt_nxt;
    logic [IDX_W-1:0]  owner, owner_nxt;
    logic [IDX_W-1:0]  ptr, ptr_nxt;
    logic [ADDR_W-1:0] addra_nxt, addrb_nxt;
    logic [WD_W-1:0]   wd, wd_nxt;

    logic              pick_vld;
    logic [IDX_W-1:0]  pick_idx;
    logic [IDX_W-1:0]  cand;

    // Scan offsets from the far end back toward ptr so the closest set bit wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand = IDX_W'((int'(ptr) + i) % NREQ);
            if (req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        owner_nxt = owner;
        ptr_nxt   = ptr;
        addra_nxt = addra;
        addrb_nxt = addrb;
        wd_nxt    = wd;
        case (state)
            ST_IDLE: begin
                if (pick_vld) begin
                    gnt_nxt           = '0;
                    gnt_nxt[pick_idx] = 1'b1;
                    owner_nxt         = pick_idx;
                    addra_nxt         = req_addra[int'(pick_idx)*ADDR_W +: ADDR_W];
                    addrb_nxt         = req_addrb[int'(pick_idx)*ADDR_W +: ADDR_W];
                    state_nxt         = ST_GRANT;
                end
            end
            ST_GRANT: begin
                wd_nxt    = '0;
                state_nxt = ST_RUN;
            end
            ST_RUN: begin
                wd_nxt = wd + 1'b1;
                // Completion wins over a timeout landing on the same cycle.
                if (karatDone) begin
                    state_nxt = ST_DONE;
                end else if (wd == WD_LAST) begin
                    state_nxt = ST_ABORT;
                end
            end
            ST_DONE, ST_ABORT: begin
                gnt_nxt   = '0;
                ptr_nxt   = IDX_W'((int'(owner) + 1) % NREQ);
                state_nxt = ST_IDLE;
            end
            default: begin
                gnt_nxt   = '0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            gnt   <= '0;
            owner <= '0;
            ptr   <= '0;
            addra <= '0;
            addrb <= '0;
            wd    <= '0;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            owner <= owner_nxt;
            ptr   <= ptr_nxt;
            addra <= addra_nxt;
            addrb <= addrb_nxt;
            wd    <= wd_nxt;
        end
    end

    assign done     = (state == ST_DONE)  ? gnt : '0;
    assign abort    = (state == ST_ABORT) ? gnt : '0;
    assign karatRst = (state != ST_RUN);
    assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_karat_core_arbiter.sv
// Self-checking bench for karat_core_arbiter: directed scenarios plus random operations
// checked against a transaction-level round-robin/watchdog model.
module tb_karat_core_arbiter;

    localparam int NREQ    = 2;
    localparam int ADDR_W  = 2;
    localparam int MAX_CYC = 8;
    localparam int AW2     = NREQ * ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [AW2-1:0]    req_addra;
    logic [AW2-1:0]    req_addrb;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic [NREQ-1:0]   abort;
    logic [ADDR_W-1:0] addra;
    logic [ADDR_W-1:0] addrb;
    logic              karatRst;
    logic              karatDone;
    logic              busy;

    int checks   = 0;
    int failures = 0;
    int mptr     = 0;

    karat_core_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .MAX_CYC(MAX_CYC)) dut (
        .clk(clk), .rst(rst), .req(req), .req_addra(req_addra), .req_addrb(req_addrb),
        .gnt(gnt), .done(done), .abort(abort), .addra(addra), .addrb(addrb),
        .karatRst(karatRst), .karatDone(karatDone), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

    // One complete operation starting from an IDLE sample point; model predicts winner and outcome.
    task automatic run_op(input logic [NREQ-1:0] reqv, input logic [AW2-1:0] ra,
                          input logic [AW2-1:0] rb, input int done_at, input bit drop,
                          input bit glitch, input bit scramble, input bit hold);
        int                win;
        int                exp_run;
        int                run_cnt;
        bit                exp_done;
        logic [NREQ-1:0]   exp_oh;
        logic [NREQ-1:0]   exp_dn;
        logic [NREQ-1:0]   exp_ab;
        logic [ADDR_W-1:0] ea;
        logic [ADDR_W-1:0] eb;
        win = -1;
        for (int i = 0; i < NREQ; i++) begin
            if (win < 0 && reqv[(mptr + i) % NREQ]) win = (mptr + i) % NREQ;
        end
        exp_oh      = '0;
        exp_oh[win] = 1'b1;
        ea          = ra[win*ADDR_W +: ADDR_W];
        eb          = rb[win*ADDR_W +: ADDR_W];
        exp_done    = (done_at >= 1 && done_at <= MAX_CYC);
        exp_run     = exp_done ? done_at : MAX_CYC;
        exp_dn      = exp_done ? exp_oh : '0;
        exp_ab      = exp_done ? '0 : exp_oh;

        req = reqv; req_addra = ra; req_addrb = rb;
        @(posedge clk); #1;
        checks++;
        if (gnt !== exp_oh) begin failures++; $display("FAIL grant_onehot: gnt=%b expected=%b", gnt, exp_oh); end
        checks++;
        if (addra !== ea || addrb !== eb) begin
            failures++; $display("FAIL grant_addr: addra=%0d addrb=%0d expected %0d %0d", addra, addrb, ea, eb);
        end
        checks++;
        if (karatRst !== 1'b1 || busy !== 1'b1 || done !== '0 || abort !== '0) begin
            failures++;
            $display("FAIL grant_ctrl: karatRst=%b busy=%b done=%b abort=%b expected 1 1 0 0", karatRst, busy, done, abort);
        end
        if (glitch) karatDone = 1'b1;
        if (scramble) begin req_addra = AW2'($urandom); req_addrb = AW2'($urandom); end

        @(posedge clk); #1;
        karatDone = 1'b0;
        run_cnt = 0;
        while (karatRst === 1'b0 && run_cnt <= MAX_CYC + 2) begin
            run_cnt++;
            checks++;
            if (gnt !== exp_oh || addra !== ea || addrb !== eb || busy !== 1'b1 || done !== '0 || abort !== '0) begin
                failures++;
                $display("FAIL run_hold: cyc=%0d gnt=%b addra=%0d addrb=%0d busy=%b done=%b abort=%b expected gnt=%b addr %0d %0d",
                         run_cnt, gnt, addra, addrb, busy, done, abort, exp_oh, ea, eb);
            end
            if (drop && run_cnt == 1) req = reqv & ~exp_oh;
            if (run_cnt == done_at) karatDone = 1'b1;
            @(posedge clk); #1;
            karatDone = 1'b0;
        end
        checks++;
        if (run_cnt !== exp_run) begin failures++; $display("FAIL run_length: cycles=%0d expected=%0d", run_cnt, exp_run); end
        checks++;
        if (done !== exp_dn || abort !== exp_ab) begin
            failures++; $display("FAIL finish_pulse: done=%b abort=%b expected done=%b abort=%b", done, abort, exp_dn, exp_ab);
        end
        checks++;
        if (gnt !== exp_oh || karatRst !== 1'b1 || busy !== 1'b1) begin
            failures++; $display("FAIL finish_ctrl: gnt=%b karatRst=%b busy=%b expected %b 1 1", gnt, karatRst, busy, exp_oh);
        end
        mptr = (win + 1) % NREQ;
        if (!hold) req = '0;

        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || gnt !== '0 || done !== '0 || abort !== '0 || karatRst !== 1'b1) begin
            failures++;
            $display("FAIL back_to_idle: busy=%b gnt=%b done=%b abort=%b karatRst=%b expected 0 0 0 0 1", busy, gnt, done, abort, karatRst);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; req_addra = '0; req_addrb = '0; karatDone = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || gnt !== '0 || done !== '0 || abort !== '0 || addra !== '0 || addrb !== '0 || karatRst !== 1'b1) begin
            failures++;
            $display("FAIL reset_values: busy=%b gnt=%b done=%b abort=%b addra=%0d addrb=%0d karatRst=%b", busy, gnt, done, abort, addra, addrb, karatRst);
        end
        rst  = 1'b0;
        mptr = 0;
    endtask

    task automatic test_idle_ignores_done();
        req = '0; karatDone = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (busy !== 1'b0 || done !== '0 || karatRst !== 1'b1) begin
                failures++; $display("FAIL idle_done_ignored: busy=%b done=%b karatRst=%b expected 0 0 1", busy, done, karatRst);
            end
        end
        karatDone = 1'b0;
    endtask

    task automatic test_fairness();
        for (int k = 0; k < 4; k++) run_op(2'b11, 4'b0110, 4'b1001, 3, 1'b0, 1'b0, 1'b0, 1'b1);
        req = '0;
    endtask

    task automatic test_single();
        run_op(2'b01, 4'h2, 4'h1, 5, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_timeout();
        run_op(2'b10, 4'b1100, 4'b0111, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(2'b11, 4'b1101, 4'b0110, 2, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_tie();
        run_op(2'b01, 4'b0011, 4'b0010, MAX_CYC, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_req_drop();
        run_op(2'b10, 4'b1000, 4'b0100, 4, 1'b1, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_run();
        run_op(2'b01, 4'h1, 4'h2, 2, 1'b0, 1'b0, 1'b0, 1'b0);
        req = 2'b10; req_addra = 4'b1111; req_addrb = 4'b1011;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; req = '0;
        checks++;
        if (busy !== 1'b0 || gnt !== '0 || done !== '0 || abort !== '0 || addra !== '0 || addrb !== '0 || karatRst !== 1'b1) begin
            failures++;
            $display("FAIL midrun_reset: busy=%b gnt=%b done=%b abort=%b addra=%0d addrb=%0d karatRst=%b", busy, gnt, done, abort, addra, addrb, karatRst);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== '0 || abort !== '0 || busy !== 1'b0) begin
            failures++; $display("FAIL midrun_silent: done=%b abort=%b busy=%b expected 0 0 0", done, abort, busy);
        end
        mptr = 0;
        run_op(2'b11, 4'b1001, 4'b0110, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 24; k++) begin
            run_op(NREQ'($urandom_range(1, 3)), AW2'($urandom), AW2'($urandom),
                   $urandom_range(0, MAX_CYC + 2), 1'($urandom), 1'($urandom),
                   1'($urandom), 1'($urandom));
        end
        req = '0;
    endtask

    initial begin
        test_reset();
        test_idle_ignores_done();
        test_fairness();
        test_single();
        test_timeout();
        test_tie();
        test_req_drop();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
